pattern_serial_tx: RTL and testbench

//  Serial bit-pattern transmitter; the sending end of the 1-bit serial stream consumed by the Mealy sequence detectors.

---
 rtl/pattern_serial_tx.sv | 130 +++++++++++++
 tb/tb_pattern_serial_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_serial_tx.sv
// Serial bit-pattern transmitter: loads pattern/len/reps over valid/ready, shifts MSB-first.
// Optional per-repetition even-parity bit under `PATTERN_TX_PARITY_EN.
module pattern_serial_tx #(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [CNT_W-1:0] load_reps,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

`ifdef PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pat_r, sh_r;
  logic [LEN_W-1:0] len_r, bit_cnt, len_eff;
  logic [CNT_W-1:0] rep_cnt;
  logic             accept, restart, frame_end;
`ifdef PATTERN_TX_PARITY_EN
  logic             par_r;
`endif

  // Zero or oversized lengths fall back to the full pattern width.
  assign len_eff = (load_len == '0 || load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = busy;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (bit_cnt == '0) begin
`ifdef PATTERN_TX_PARITY_EN
        state_nxt = PAR;
`else
        if (rep_cnt != '0) restart = 1'b1;
        else begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
`endif
      end
`ifdef PATTERN_TX_PARITY_EN
      PAR: if (rep_cnt != '0) begin
        state_nxt = SEND;
        restart   = 1'b1;
      end else begin
        state_nxt = IDLE;
        frame_end = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // 'out' always holds the bit currently on the wire; sh_r holds the bits still to come.
  always_ff @(posedge clock) begin
    if (reset) begin
      out     <= IDLE_LVL;
      done    <= 1'b0;
      pat_r   <= '0;
      sh_r    <= '0;
      len_r   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
`ifdef PATTERN_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      done <= frame_end;
      if (accept) begin
        pat_r   <= load_data;
        sh_r    <= {load_data[WIDTH-2:0], 1'b0};
        out     <= load_data[WIDTH-1];
        len_r   <= len_eff;
        bit_cnt <= len_eff - LEN_W'(1);
        rep_cnt <= load_reps;
`ifdef PATTERN_TX_PARITY_EN
        par_r   <= load_data[WIDTH-1];
`endif
      end else if (restart) begin
        sh_r    <= {pat_r[WIDTH-2:0], 1'b0};
        out     <= pat_r[WIDTH-1];
        bit_cnt <= len_r - LEN_W'(1);
        rep_cnt <= rep_cnt - CNT_W'(1);
`ifdef PATTERN_TX_PARITY_EN
        par_r   <= pat_r[WIDTH-1];
`endif
      end else if (frame_end) begin
        out <= IDLE_LVL;
      end else if (state == SEND) begin
        if (bit_cnt != '0) begin
          out     <= sh_r[WIDTH-1];
          sh_r    <= {sh_r[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt - LEN_W'(1);
`ifdef PATTERN_TX_PARITY_EN
          par_r   <= par_r ^ sh_r[WIDTH-1];
        end else begin
          out <= par_r;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Scoreboard bench for pattern_serial_tx: expected bit stream queued at load, compared per cycle.
module tb_pattern_serial_tx;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_data = '0;
  logic [3:0] load_len = '0;
  logic [3:0] load_reps = '0;
  logic       out, out_valid, busy, done;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  pattern_serial_tx #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .IDLE_LVL(1'b0)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .load_reps(load_reps),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Reference stream: MSB-first, clamped length, optional even parity per repetition.
  function automatic int push_frame(logic [7:0] d, logic [3:0] l, logic [3:0] r);
    int n = int'(l);
    int cnt = 0;
    logic p;
    if (l == 0 || l > 8) n = 8;
    for (int k = 0; k <= int'(r); k++) begin
      p = 1'b0;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(d[7-i]);
        p = p ^ d[7-i];
        cnt++;
      end
`ifdef PATTERN_TX_PARITY_EN
      exp_q.push_back(p);
      cnt++;
`endif
    end
    return cnt;
  endfunction

  // Leaves the bench at the negedge of the first frame cycle with load_valid dropped unless held.
  task automatic start(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r, input bit hold);
    @(negedge clock);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: load_ready=%b want 1", load_ready);
    end
    load_valid = 1'b1; load_data = d; load_len = l; load_reps = r;
    @(negedge clock);
    if (!hold) load_valid = 1'b0;
  endtask

  task automatic check_bits(input string nm, input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_underflow: bit %0d has no expected value", nm, i);
      end else begin
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || out !== e || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s_bit%0d: out=%b out_valid=%b busy=%b done=%b want out=%b valid=1 busy=1 done=0",
                   nm, i, out, out_valid, busy, done, e);
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic check_done(input string nm);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b out_valid=%b busy=%b out=%b ready=%b want 1,0,0,0,1",
               nm, done, out_valid, busy, out, load_ready);
    end
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: done=%b out_valid=%b busy=%b out=%b ready=%b want 0,0,0,0,1",
               nm, done, out_valid, busy, out, load_ready);
    end
  endtask

  task automatic run_frame(input string nm, input logic [7:0] d, input logic [3:0] l, input logic [3:0] r,
                           input int want_n);
    int n;
    n = push_frame(d, l, r);
    checks++;
    if (n != want_n) begin
      errors++;
      $display("FAIL %s_len: model frame length %0d want %0d", nm, n, want_n);
    end
    start(d, l, r, 1'b0);
    check_bits(nm, n);
    check_done(nm);
    @(negedge clock);
    check_idle(nm);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    check_idle("reset");
    // reset and load_valid together: nothing accepted
    load_valid = 1'b1; load_data = 8'hFF; load_len = 4'd8; load_reps = 4'd0;
    @(negedge clock);
    reset = 1'b0; load_valid = 1'b0;
    check_idle("reset_wins");
    @(negedge clock);
    check_idle("reset_wins2");
  endtask

  task automatic test_basic;
`ifdef PATTERN_TX_PARITY_EN
    run_frame("basic", 8'b0101_0000, 4'd4, 4'd0, 5);
`else
    run_frame("basic", 8'b0101_0000, 4'd4, 4'd0, 4);
`endif
  endtask

  task automatic test_repeat;
`ifdef PATTERN_TX_PARITY_EN
    run_frame("repeat", 8'b0101_0000, 4'd4, 4'd2, 15);
`else
    run_frame("repeat", 8'b0101_0000, 4'd4, 4'd2, 12);
`endif
  endtask

  task automatic test_clamp;
`ifdef PATTERN_TX_PARITY_EN
    run_frame("clamp0", 8'hA5, 4'd0, 4'd0, 9);
    run_frame("clamp9", 8'hA5, 4'd9, 4'd0, 9);
`else
    run_frame("clamp0", 8'hA5, 4'd0, 4'd0, 8);
    run_frame("clamp9", 8'hA5, 4'd9, 4'd0, 8);
`endif
  endtask

  task automatic test_max_reps;
`ifdef PATTERN_TX_PARITY_EN
    run_frame("maxreps", 8'h80, 4'd1, 4'd15, 32);
`else
    run_frame("maxreps", 8'h80, 4'd1, 4'd15, 16);
`endif
  endtask

  task automatic test_ignore;
    int n;
    n = push_frame(8'hC3, 4'd8, 4'd0);
    start(8'hC3, 4'd8, 4'd0, 1'b0);
    check_bits("ignore", 2);
    load_valid = 1'b1; load_data = 8'h0F; load_len = 4'd3; load_reps = 4'd5;
    check_bits("ignore", 1);
    load_valid = 1'b0;
    check_bits("ignore", n - 3);
    check_done("ignore");
    @(negedge clock);
    check_idle("ignore");
  endtask

  task automatic test_reset_mid;
    int n;
    n = push_frame(8'hA5, 4'd8, 4'd0);
    start(8'hA5, 4'd8, 4'd0, 1'b0);
    check_bits("rstmid", 2);
    reset = 1'b1;
    check_bits("rstmid", 1);
    reset = 1'b0;
    exp_q.delete();
    check_idle("rstmid_after");
    @(negedge clock);
    check_idle("rstmid_nodone");
    run_frame("rstmid_new", 8'b1100_0000, 4'd2, 4'd0, n > 8 ? 3 : 2);
  endtask

  task automatic test_back_to_back;
    int n1, n2;
    n1 = push_frame(8'b1011_0000, 4'd4, 4'd0);
    n2 = push_frame(8'b1011_0000, 4'd4, 4'd0);
    start(8'b1011_0000, 4'd4, 4'd0, 1'b1);
    check_bits("b2b_a", n1);
    check_done("b2b_a");
    @(negedge clock);
    load_valid = 1'b0;
    check_bits("b2b_b", n2);
    check_done("b2b_b");
    @(negedge clock);
    check_idle("b2b_b");
  endtask

  task automatic test_parity;
`ifdef PATTERN_TX_PARITY_EN
    run_frame("parity", 8'b1101_0000, 4'd4, 4'd1, 10);
`else
    run_frame("parity", 8'b1101_0000, 4'd4, 4'd1, 8);
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_repeat;
    test_clamp;
    test_max_reps;
    test_ignore;
    test_reset_mid;
    test_back_to_back;
    test_parity;
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
